// File: rtl/apb_arbiter_if.sv
// Bundle of requester-side command/response signals and the APB master bus
// for apb_arbiter. "master" is the arbiter's view; "slave" is the environment's view.
interface apb_arbiter_if #(
  parameter int APB_AW = 32,
  parameter int APB_DW = 32,
  parameter int APB_SW = APB_DW / 8,
  parameter int N_REQ  = 2
);
  logic [N_REQ-1:0]        reqValid;
  logic [N_REQ-1:0]        reqWrite;
  logic [N_REQ*APB_AW-1:0] reqAddr;
  logic [N_REQ*APB_DW-1:0] reqWData;
  logic [N_REQ*APB_SW-1:0] reqStrb;
  logic [N_REQ*3-1:0]      reqProt;
  logic [N_REQ-1:0]        reqAccept;
  logic [N_REQ-1:0]        rspValid;
  logic [APB_DW-1:0]       rspRData;
  logic                    rspSlvErr;

  logic                    apbPSel;
  logic                    apbPEnable;
  logic                    apbPWrite;
  logic [APB_AW-1:0]       apbPAddr;
  logic [APB_DW-1:0]       apbPWData;
  logic [APB_SW-1:0]       apbPStrb;
  logic [2:0]              apbPProt;
  logic [APB_DW-1:0]       apbPRData;
  logic                    apbPReady;
  logic                    apbPSlvErr;

  modport master (
    input  reqValid, reqWrite, reqAddr, reqWData, reqStrb, reqProt,
    output reqAccept, rspValid, rspRData, rspSlvErr,
    output apbPSel, apbPEnable, apbPWrite, apbPAddr, apbPWData, apbPStrb, apbPProt,
    input  apbPRData, apbPReady, apbPSlvErr
  );

  modport slave (
    output reqValid, reqWrite, reqAddr, reqWData, reqStrb, reqProt,
    input  reqAccept, rspValid, rspRData, rspSlvErr,
    input  apbPSel, apbPEnable, apbPWrite, apbPAddr, apbPWData, apbPStrb, apbPProt,
    output apbPRData, apbPReady, apbPSlvErr
  );
endinterface

// File: rtl/apb_arbiter.sv
// Round-robin arbiter funnelling N_REQ command ports onto one APB master,
// with optional ACCESS-phase timeout that aborts with an error response.
module apb_arbiter #(
  parameter int APB_AW  = 32,
  parameter int APB_DW  = 32,
  parameter int APB_SW  = APB_DW / 8,
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 0
) (
  input  logic          ckApb,
  input  logic          rstApb,
  apb_arbiter_if.master bus
);
  localparam int GW = $clog2(N_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic [APB_SW-1:0] strb;
    logic [2:0]        prot;
  } cmd_t;

  state_t            state, state_nx;
  cmd_t              cmd, cmd_sel;
  logic [GW-1:0]     last, win;
  logic [N_REQ-1:0]  win_oh, own_oh;
  logic [CW-1:0]     wcnt;
  logic              any_req, busy, done, tmo, arb_pt, accept;
  logic [N_REQ-1:0]  rsp_vld;
  logic [APB_DW-1:0] rsp_rdata;
  logic              rsp_err;

  assign any_req = |bus.reqValid;
  assign busy    = (state != IDLE);
  assign done    = (state == ACCESS) && bus.apbPReady;
  assign tmo     = (TIMEOUT > 0) && (state == ACCESS) && !bus.apbPReady &&
                   (wcnt == CW'(TIMEOUT - 1));
  // a timeout abort deliberately does not arbitrate
  assign arb_pt  = (state == IDLE) || done;
  assign accept  = arb_pt && any_req && !rstApb;

  // winner = smallest rotational distance from the requester after last grant
  always_comb begin
    int d, best;
    d    = 0;
    best = N_REQ;
    win  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      d = (i + N_REQ - 1 - int'(last)) % N_REQ;
      if (bus.reqValid[i] && d < best) begin
        best = d;
        win  = GW'(i);
      end
    end
  end

  always_comb begin
    win_oh = '0;
    own_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_oh[i] = any_req && (win == GW'(i));
      own_oh[i] = (last == GW'(i));
    end
  end

  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        cmd_sel.write = bus.reqWrite[i];
        cmd_sel.addr  = bus.reqAddr[i*APB_AW +: APB_AW];
        cmd_sel.wdata = bus.reqWData[i*APB_DW +: APB_DW];
        cmd_sel.strb  = bus.reqStrb[i*APB_SW +: APB_SW];
        cmd_sel.prot  = bus.reqProt[i*3 +: 3];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS: begin
        if (done)     state_nx = accept ? SETUP : IDLE;
        else if (tmo) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ckApb or posedge rstApb) begin
    if (rstApb) begin
      state     <= IDLE;
      cmd       <= '0;
      last      <= GW'(N_REQ - 1);
      wcnt      <= '0;
      rsp_vld   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cmd  <= cmd_sel;
        last <= win;
      end
      if ((TIMEOUT > 0) && (state == ACCESS) && !bus.apbPReady && !tmo)
        wcnt <= wcnt + CW'(1);
      else
        wcnt <= '0;
      rsp_vld <= '0;
      if (done) begin
        rsp_vld   <= own_oh;
        rsp_rdata <= cmd.write ? '0 : bus.apbPRData;
        rsp_err   <= bus.apbPSlvErr;
      end else if (tmo) begin
        rsp_vld   <= own_oh;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

  assign bus.reqAccept  = accept ? win_oh : '0;
  assign bus.rspValid   = rsp_vld;
  assign bus.rspRData   = rsp_rdata;
  assign bus.rspSlvErr  = rsp_err;

  assign bus.apbPSel    = busy;
  assign bus.apbPEnable = (state == ACCESS);
  assign bus.apbPWrite  = busy && cmd.write;
  assign bus.apbPAddr   = busy ? cmd.addr : '0;
  assign bus.apbPProt   = busy ? cmd.prot : '0;
  assign bus.apbPWData  = (busy && cmd.write) ? cmd.wdata : '0;
  assign bus.apbPStrb   = (busy && cmd.write) ? cmd.strb  : '0;
endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: vector table, directed corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_apb_arbiter;
  localparam int NR  = 3;
  localparam int TMO = 4;

  logic clk, rst;
  int   nvec = 0;
  int   nerr = 0;

  apb_arbiter_if #(.APB_AW(32), .APB_DW(32), .APB_SW(4), .N_REQ(NR)) bus ();

  apb_arbiter #(.APB_AW(32), .APB_DW(32), .APB_SW(4), .N_REQ(NR), .TIMEOUT(TMO)) dut (
    .ckApb (clk),
    .rstApb(rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  vld;
    logic        rdy;
    logic [2:0]  acc;
    logic        sel;
    logic        en;
    logic [2:0]  rsp;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl[15];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  p;
  } req_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic setreq(input int i, input bit v, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    bus.reqValid[i]        = v;
    bus.reqWrite[i]        = w;
    bus.reqAddr[i*32 +: 32] = a;
    bus.reqWData[i*32 +: 32] = d;
    bus.reqStrb[i*4 +: 4]  = s;
    bus.reqProt[i*3 +: 3]  = p;
  endtask

  task automatic clr();
    bus.reqValid   = '0;
    bus.reqWrite   = '0;
    bus.reqAddr    = '0;
    bus.reqWData   = '0;
    bus.reqStrb    = '0;
    bus.reqProt    = '0;
    bus.apbPReady  = 1'b0;
    bus.apbPSlvErr = 1'b0;
    bus.apbPRData  = '0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    samp();
    tick();
    rst = 1'b0;
  endtask

  // reference model state
  int          m_last, m_age, m_own, win;
  bit          m_busy, arb, rdy, mdone, mtmo;
  req_t        m_cur;
  logic [2:0]  m_rspv, ea;
  logic [31:0] m_rdata;
  bit          m_err;
  req_t        pend[NR];
  bit          pv[NR];

  initial begin
    tbl[0]  = '{3'b011, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 32'h000};
    tbl[1]  = '{3'b011, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 32'h100};
    tbl[2]  = '{3'b011, 1'b1, 3'b010, 1'b1, 1'b1, 3'b000, 32'h100};
    tbl[3]  = '{3'b011, 1'b1, 3'b000, 1'b1, 1'b0, 3'b001, 32'h200};
    tbl[4]  = '{3'b011, 1'b1, 3'b001, 1'b1, 1'b1, 3'b000, 32'h200};
    tbl[5]  = '{3'b100, 1'b1, 3'b000, 1'b1, 1'b0, 3'b010, 32'h100};
    tbl[6]  = '{3'b100, 1'b0, 3'b000, 1'b1, 1'b1, 3'b000, 32'h100};
    tbl[7]  = '{3'b110, 1'b1, 3'b010, 1'b1, 1'b1, 3'b000, 32'h100};
    tbl[8]  = '{3'b100, 1'b0, 3'b000, 1'b1, 1'b0, 3'b001, 32'h200};
    tbl[9]  = '{3'b100, 1'b1, 3'b100, 1'b1, 1'b1, 3'b000, 32'h200};
    tbl[10] = '{3'b000, 1'b1, 3'b000, 1'b1, 1'b0, 3'b010, 32'h300};
    tbl[11] = '{3'b000, 1'b1, 3'b000, 1'b1, 1'b1, 3'b000, 32'h300};
    tbl[12] = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b100, 32'h000};
    tbl[13] = '{3'b001, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 32'h000};
    tbl[14] = '{3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 32'h100};

    // reset state, with requests pending
    rst = 1'b1;
    clr();
    tick();
    bus.reqValid = 3'b111;
    samp();
    chk("rst accept", bus.reqAccept, 3'b000);
    chk("rst psel",   bus.apbPSel, 1'b0);
    chk("rst penable", bus.apbPEnable, 1'b0);
    chk("rst paddr",  bus.apbPAddr, 32'h0);
    chk("rst rspvalid", bus.rspValid, 3'b000);
    chk("rst rspdata", bus.rspRData, 32'h0);
    chk("rst rsperr", bus.rspSlvErr, 1'b0);
    tick();
    rst = 1'b0;
    clr();

    // table: rotation, back-to-back, wait states, idle return
    for (int i = 0; i < NR; i++)
      setreq(i, 1'b0, 1'b1, 32'h100 * (i + 1), 32'hA0 + i, 4'hF, 3'(i));
    for (int k = 0; k < 15; k++) begin
      bus.reqValid  = tbl[k].vld;
      bus.apbPReady = tbl[k].rdy;
      samp();
      chk($sformatf("tbl%0d accept", k), bus.reqAccept, tbl[k].acc);
      chk($sformatf("tbl%0d psel", k), bus.apbPSel, tbl[k].sel);
      chk($sformatf("tbl%0d penable", k), bus.apbPEnable, tbl[k].en);
      chk($sformatf("tbl%0d rspvalid", k), bus.rspValid, tbl[k].rsp);
      chk($sformatf("tbl%0d paddr", k), bus.apbPAddr, tbl[k].addr);
      tick();
    end

    // single read, zero wait
    do_reset();
    setreq(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 3'b010);
    samp();
    chk("s1 accept", bus.reqAccept, 3'b001);
    tick();
    bus.reqValid = '0;
    samp();
    chk("s1 setup psel", bus.apbPSel, 1'b1);
    chk("s1 setup penable", bus.apbPEnable, 1'b0);
    chk("s1 paddr", bus.apbPAddr, 32'h100);
    chk("s1 pprot", bus.apbPProt, 3'b010);
    chk("s1 pwrite", bus.apbPWrite, 1'b0);
    chk("s1 pwdata", bus.apbPWData, 32'h0);
    chk("s1 pstrb", bus.apbPStrb, 4'h0);
    tick();
    bus.apbPReady = 1'b1;
    bus.apbPRData = 32'hDEADBEEF;
    samp();
    chk("s1 access penable", bus.apbPEnable, 1'b1);
    tick();
    bus.apbPReady = 1'b0;
    bus.apbPRData = '0;
    samp();
    chk("s1 rspvalid", bus.rspValid, 3'b001);
    chk("s1 rspdata", bus.rspRData, 32'hDEADBEEF);
    chk("s1 rsperr", bus.rspSlvErr, 1'b0);
    chk("s1 idle psel", bus.apbPSel, 1'b0);
    tick();
    samp();
    chk("s1 rspvalid pulse", bus.rspValid, 3'b000);
    chk("s1 rspdata hold", bus.rspRData, 32'hDEADBEEF);
    tick();

    // timeout abort; a waiting requester must not be accepted at the abort
    setreq(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 3'b000);
    samp();
    chk("s4 accept", bus.reqAccept, 3'b001);
    tick();
    bus.reqValid = '0;
    samp();
    chk("s4 setup", bus.apbPEnable, 1'b0);
    tick();
    for (int k = 0; k < TMO; k++) begin
      bus.apbPRData = 32'h12345678;
      if (k == 0) setreq(1, 1'b1, 1'b1, 32'h300, 32'h1, 4'h1, 3'b000);
      samp();
      chk($sformatf("s4 access%0d penable", k), bus.apbPEnable, 1'b1);
      chk($sformatf("s4 access%0d accept", k), bus.reqAccept, 3'b000);
      tick();
    end
    samp();
    chk("s4 abort psel", bus.apbPSel, 1'b0);
    chk("s4 rspvalid", bus.rspValid, 3'b001);
    chk("s4 rsperr", bus.rspSlvErr, 1'b1);
    chk("s4 rspdata", bus.rspRData, 32'h0);
    chk("s4 idle accept", bus.reqAccept, 3'b010);
    tick();

    // write with 3 wait states ending in a slave error
    do_reset();
    setreq(1, 1'b1, 1'b1, 32'h40, 32'h5555AAAA, 4'b0011, 3'b001);
    samp();
    chk("s3 accept", bus.reqAccept, 3'b010);
    tick();
    bus.reqValid = '0;
    samp();
    chk("s3 pwrite", bus.apbPWrite, 1'b1);
    chk("s3 pwdata", bus.apbPWData, 32'h5555AAAA);
    chk("s3 pstrb", bus.apbPStrb, 4'b0011);
    chk("s3 paddr", bus.apbPAddr, 32'h40);
    tick();
    for (int k = 0; k < 3; k++) begin
      samp();
      chk($sformatf("s3 wait%0d penable", k), bus.apbPEnable, 1'b1);
      tick();
    end
    bus.apbPReady  = 1'b1;
    bus.apbPSlvErr = 1'b1;
    samp();
    chk("s3 last penable", bus.apbPEnable, 1'b1);
    tick();
    bus.apbPReady  = 1'b0;
    bus.apbPSlvErr = 1'b0;
    samp();
    chk("s3 rspvalid", bus.rspValid, 3'b010);
    chk("s3 rsperr", bus.rspSlvErr, 1'b1);
    chk("s3 rspdata", bus.rspRData, 32'h0);
    chk("s3 psel", bus.apbPSel, 1'b0);
    tick();

    // asynchronous reset in the middle of ACCESS
    do_reset();
    setreq(2, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 3'b000);
    samp();
    chk("s5 accept", bus.reqAccept, 3'b100);
    tick();
    bus.reqValid = '0;
    samp();
    tick();
    samp();
    chk("s5 access penable", bus.apbPEnable, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("s5 async psel", bus.apbPSel, 1'b0);
    chk("s5 async penable", bus.apbPEnable, 1'b0);
    bus.reqValid = 3'b111;
    #1;
    chk("s5 rst accept", bus.reqAccept, 3'b000);
    tick();
    bus.apbPReady = 1'b1;
    samp();
    chk("s5 rst rspvalid", bus.rspValid, 3'b000);
    tick();
    rst = 1'b0;
    samp();
    chk("s5 post accept", bus.reqAccept, 3'b001);
    chk("s5 post rspvalid", bus.rspValid, 3'b000);
    tick();

    // randomized run against the transaction model
    do_reset();
    m_last = NR - 1; m_busy = 0; m_age = 0; m_own = 0;
    m_rspv = '0; m_rdata = '0; m_err = 0;
    for (int i = 0; i < NR; i++) pv[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1;
          pend[i].w = 1'($urandom_range(0, 1));
          pend[i].a = $urandom;
          pend[i].d = $urandom;
          pend[i].s = 4'($urandom);
          pend[i].p = 3'($urandom);
        end else if (pv[i] && $urandom_range(0, 15) == 0) begin
          pv[i] = 0;
        end
        setreq(i, pv[i], pend[i].w, pend[i].a, pend[i].d, pend[i].s, pend[i].p);
      end
      rdy = 1'($urandom_range(0, 1));
      bus.apbPReady  = rdy;
      bus.apbPSlvErr = ($urandom_range(0, 3) == 0);
      bus.apbPRData  = $urandom;
      samp();

      arb = !m_busy || (m_age >= 2 && rdy);
      win = -1;
      if (arb)
        for (int k = 1; k <= NR; k++)
          if (win < 0 && pv[(m_last + k) % NR]) win = (m_last + k) % NR;
      ea = (win >= 0) ? 3'(1 << win) : 3'b000;

      chk("rnd accept", bus.reqAccept, ea);
      chk("rnd psel", bus.apbPSel, m_busy);
      chk("rnd penable", bus.apbPEnable, m_busy && m_age >= 2);
      chk("rnd pwrite", bus.apbPWrite, m_busy && m_cur.w);
      chk("rnd paddr", bus.apbPAddr, m_busy ? m_cur.a : 32'h0);
      chk("rnd pprot", bus.apbPProt, m_busy ? m_cur.p : 3'h0);
      chk("rnd pwdata", bus.apbPWData, (m_busy && m_cur.w) ? m_cur.d : 32'h0);
      chk("rnd pstrb", bus.apbPStrb, (m_busy && m_cur.w) ? m_cur.s : 4'h0);
      chk("rnd rspvalid", bus.rspValid, m_rspv);
      chk("rnd rspdata", bus.rspRData, m_rdata);
      chk("rnd rsperr", bus.rspSlvErr, m_err);

      mdone = m_busy && m_age >= 2 && rdy;
      mtmo  = m_busy && m_age >= 2 && !rdy && (m_age - 1) == TMO;
      m_rspv = '0;
      if (mdone) begin
        m_rspv  = 3'(1 << m_own);
        m_rdata = m_cur.w ? 32'h0 : bus.apbPRData;
        m_err   = bus.apbPSlvErr;
      end else if (mtmo) begin
        m_rspv  = 3'(1 << m_own);
        m_rdata = 32'h0;
        m_err   = 1'b1;
      end
      if (win >= 0) begin
        m_cur  = pend[win];
        m_own  = win;
        m_last = win;
        m_busy = 1;
        m_age  = 1;
        pv[win] = 0;
      end else if (mdone || mtmo) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_age++;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
